// File: rtl/sopc_cap_arb_pkg.sv
// sopc_cap_arb_pkg
// Shared types and constants for the capture-RAM arbiter:
//   - arbiter ownership states (IDLE / OWN0 / OWN1)
//   - RAM port widths (ADDR_W, DATA_W, BE_W)
//   - default RAM depth and lock-burst limit
package sopc_cap_arb_pkg;

  localparam int ADDR_W        = 13;
  localparam int DATA_W        = 32;
  localparam int BE_W          = 4;
  localparam int CNT_W         = 8;
  localparam int DEF_DEPTH     = 5000;
  localparam int DEF_MAX_BURST = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Ownership state a locked grant moves to, by master index.
  function automatic arb_state_t own_state(input logic who);
    return who ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/sopc_cap_ram_arbiter_if.sv
// sopc_cap_ram_arbiter_if
// One requester's Avalon-style memory-mapped port into the arbiter.
//   master modport : the requester (drives address/byteenable/read/write/
//                    writedata/lock, receives waitrequest/readdata/readdatavalid)
//   slave modport  : the arbiter side of the same port
interface sopc_cap_ram_arbiter_if;
  import sopc_cap_arb_pkg::*;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              lock;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata, lock,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata, lock,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/sopc_cap_arb_pick.sv
// sopc_cap_arb_pick
// Combinational 2-way grant decision.
//   req[1:0]  : per-master access request (read or write)
//   state     : current ownership state
//   rr_last   : index of the master granted most recently
//   gnt[1:0]  : one-hot grant (all zero when nobody requests)
module sopc_cap_arb_pick
  import sopc_cap_arb_pkg::*;
(
  input  logic [1:0]  req,
  input  arb_state_t  state,
  input  logic        rr_last,
  output logic [1:0]  gnt
);

  always_comb begin
    gnt = 2'b00;
    case (state)
      OWN0: begin
        if (req[0])      gnt = 2'b01;
        else if (req[1]) gnt = 2'b10;
      end
      OWN1: begin
        if (req[1])      gnt = 2'b10;
        else if (req[0]) gnt = 2'b01;
      end
      default: begin
        case (req)
          2'b01:   gnt = 2'b01;
          2'b10:   gnt = 2'b10;
          // Tie: the master that was not served last goes first.
          2'b11:   gnt = rr_last ? 2'b01 : 2'b10;
          default: gnt = 2'b00;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/sopc_cap_ram_arbiter.sv
// sopc_cap_ram_arbiter
// Shares the capture system's single-port 32-bit on-chip RAM between the
// anemometer capture writer (m0) and the host reader (m1). Round-robin
// arbitration with optional bounded locked bursts; read data returns one
// cycle after acceptance with a per-master valid strobe.
//
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   m0, m1          : requester ports (sopc_cap_ram_arbiter_if.slave)
//   mem_*           : RAM port (address/byteenable/writedata/chipselect/
//                     write/clken out, readdata in, 1-cycle read latency)
//   err             : one-cycle pulse on an out-of-range access
//
// Build option: SOPC_CAP_ARB_ADDR_CHECK_EN -- when defined, accesses at
// address >= DEPTH are accepted without touching the RAM, pulse err, and
// reads of them return zero. When undefined, addresses pass through and
// err is tied low.
module sopc_cap_ram_arbiter
  import sopc_cap_arb_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                clk,
  input  logic                reset,
  sopc_cap_ram_arbiter_if.slave m0,
  sopc_cap_ram_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [BE_W-1:0]     mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                err
);

  localparam logic [ADDR_W:0]  DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] MAX_B   = CNT_W'(MAX_BURST);

  arb_state_t        state, state_nx;
  logic              rr_last, rr_nx;
  logic [CNT_W-1:0]  burst_cnt, cnt_nx;
  logic              rdv0, rdv1;
  logic [1:0]        req, gnt_pick, gnt;
  logic              any_gnt, sel1, oor;
  logic [ADDR_W-1:0] sel_addr, addr_q;
  logic [BE_W-1:0]   sel_be, be_q;
  logic [DATA_W-1:0] sel_wdata, wdata_q, rdata;
  logic              sel_write, sel_lock;

  // Request / grant stage
  assign req = {m1.read | m1.write, m0.read | m0.write};

  sopc_cap_arb_pick u_pick (
    .req     (req),
    .state   (state),
    .rr_last (rr_last),
    .gnt     (gnt_pick)
  );

  // Nothing is accepted while reset is held, so both masters see waitrequest.
  assign gnt     = reset ? 2'b00 : gnt_pick;
  assign any_gnt = |gnt;
  assign sel1    = gnt[1];

  assign sel_addr  = sel1 ? m1.address    : m0.address;
  assign sel_be    = sel1 ? m1.byteenable : m0.byteenable;
  assign sel_wdata = sel1 ? m1.writedata  : m0.writedata;
  assign sel_write = sel1 ? m1.write      : m0.write;
  assign sel_lock  = sel1 ? m1.lock       : m0.lock;

  assign m0.waitrequest = ~gnt[0];
  assign m1.waitrequest = ~gnt[1];

`ifdef SOPC_CAP_ARB_ADDR_CHECK_EN
  assign oor = any_gnt && ({1'b0, sel_addr} >= DEPTH_W);
`else
  logic unused_depth;
  assign oor          = 1'b0;
  assign unused_depth = ^DEPTH_W;
`endif

  // An idle bus keeps presenting the last granted address/data.
  assign mem_address    = any_gnt ? sel_addr  : addr_q;
  assign mem_byteenable = any_gnt ? sel_be    : be_q;
  assign mem_writedata  = any_gnt ? sel_wdata : wdata_q;
  assign mem_chipselect = any_gnt & ~oor;
  assign mem_write      = any_gnt & ~oor & sel_write;
  assign mem_clken      = ~reset;
  assign err            = oor;

  always_comb begin
    state_nx = IDLE;
    cnt_nx   = '0;
    rr_nx    = rr_last;
    if (any_gnt) begin
      rr_nx = sel1;
      if (sel_lock) begin
        // A lock continuing the current owner's run extends it; otherwise
        // this grant starts a new run.
        cnt_nx = (state == own_state(sel1)) ? burst_cnt + 1'b1 : CNT_W'(1);
        if (cnt_nx >= MAX_B) begin
          // Run exhausted: drop ownership; rr_last already favours the peer.
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          state_nx = own_state(sel1);
        end
      end
    end
  end

  // Registered control stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_last   <= 1'b1;
      burst_cnt <= '0;
      rdv0      <= 1'b0;
      rdv1      <= 1'b0;
    end else begin
      state     <= state_nx;
      rr_last   <= rr_nx;
      burst_cnt <= cnt_nx;
      rdv0      <= gnt[0] & m0.read & ~m0.write;
      rdv1      <= gnt[1] & m1.read & ~m1.write;
    end
  end

  always_ff @(posedge clk) begin
    if (any_gnt) begin
      addr_q  <= sel_addr;
      be_q    <= sel_be;
      wdata_q <= sel_wdata;
    end
  end

  // Read return stage
`ifdef SOPC_CAP_ARB_ADDR_CHECK_EN
  logic rd_oor;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_oor <= 1'b0;
    else       rd_oor <= oor;
  end
  assign rdata = rd_oor ? '0 : mem_readdata;
`else
  assign rdata = mem_readdata;
`endif

  assign m0.readdata      = rdata;
  assign m1.readdata      = rdata;
  assign m0.readdatavalid = rdv0;
  assign m1.readdatavalid = rdv1;

endmodule
